// File: rtl/tick_meter_pkg.sv
// Shared definitions for the tick period meter.
//   state_t : measurement FSM states (IDLE = waiting for the first edge,
//             RUN = counting clk cycles between strobe edges)
//   CNT_W   : width of the cycle counter and of the reported period
//   ERR_W   : width of the saturating out-of-tolerance counter
package tick_meter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int CNT_W = 16;
  localparam int ERR_W = 8;

endpackage

// File: rtl/rise_det.sv
// Rising-edge detector for a signal already synchronous to clk.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears the delayed copy
//   d     : input level
//   pulse : high in the cycle where d is 1 and was 0 on the previous cycle
//           (a level held high yields a single pulse)
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_p0 <= 1'b0;
    end else begin
      d_p0 <= d;
    end
  end

  assign pulse = d & ~d_p0;

endmodule

// File: rtl/tick_period_meter.sv
// Measures the period, in clk cycles, of a clock-enable strobe and flags
// strobe loss.
//   Parameters : FCLK  clock frequency in Hz
//                FTICK nominal strobe frequency in Hz (EXP = FCLK/FTICK)
//                TOL   allowed |period - EXP| in cycles
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   ce_in      : strobe under measurement (rising edges are measured)
//   period     : last measured period in cycles
//   period_vld : one-cycle pulse when period updates (1 clk after the edge)
//   in_tol     : last period within EXP +/- TOL
//   tmo        : one-cycle pulse when no edge arrives within TMO cycles
//   lost       : sticky strobe-loss flag, cleared by the next measurement
//   err_cnt    : saturating count of out-of-tolerance periods
// Build option: define TICK_PERIOD_METER_ERRCNT_EN to build the error
// counter; without it err_cnt is tied to zero.
module tick_period_meter
  import tick_meter_pkg::*;
#(
  parameter int FCLK  = 50000000,
  parameter int FTICK = 1000,
  parameter int TOL   = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce_in,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             in_tol,
  output logic             tmo,
  output logic             lost,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int EXP = FCLK / FTICK;
  localparam int TMO = EXP + EXP / 4;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO - 1);

  // The timeout must be reachable by the 16-bit counter.
  if (TMO > 65535 || TMO < 1) begin : g_bad_tmo
    $error("tick_period_meter: TMO=%0d does not fit the 16-bit counter", TMO);
  end

  // |m - EXP| <= TOL, evaluated in signed 32-bit arithmetic so a TOL larger
  // than EXP cannot wrap.
  function automatic logic within_tol(input logic [CNT_W-1:0] m);
    int signed diff;
    diff = int'(m) - EXP;
    if (diff < 0) diff = -diff;
    return (diff <= TOL);
  endfunction

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] meas;
  logic             rise;
  logic             meas_go;
  logic             tmo_go;

  rise_det u_rise_det (
    .clk   (clk),
    .rst   (rst),
    .d     (ce_in),
    .pulse (rise)
  );

  // cnt holds (cycles since the last edge) - 1, so the period is cnt + 1.
  assign meas = cnt + 1'b1;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    meas_go = 1'b0;
    tmo_go  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // An edge on the last allowed cycle still counts as a measurement.
        if (rise) begin
          meas_go = 1'b1;
          cnt_d   = '0;
        end else if (cnt == TMO_LAST) begin
          tmo_go  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Stage boundary: FSM, counter and result registers (1-cycle latency).
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      in_tol     <= 1'b0;
      tmo        <= 1'b0;
      lost       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      period_vld <= meas_go;
      tmo        <= tmo_go;
      if (meas_go) begin
        period <= meas;
        in_tol <= within_tol(meas);
        lost   <= 1'b0;
      end else if (tmo_go) begin
        lost   <= 1'b1;
      end
    end
  end

`ifdef TICK_PERIOD_METER_ERRCNT_EN
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (meas_go && !within_tol(meas)) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule
